// File: rtl/comp_acc.sv
// Purpose: accumulates a frame of signed complex terms {xr,yr} into one complex sum {acc_x,acc_y}.
// Latency: the result is valid one cycle after the closing term is accepted (NACC terms or in_last).
// Backpressure: in_rdy drops while a result is held; one bubble cycle after each result handoff.
module comp_acc #(
    parameter  int DWIDTH = 8,
    parameter  int NACC   = 16,
    localparam int IWIDTH = 2*DWIDTH+2,
    localparam int CWIDTH = $clog2(NACC+1),
    localparam int AWIDTH = IWIDTH+$clog2(NACC)
) (
    input  logic                  clk,
    input  logic                  sw_rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic                  in_last,
    input  logic [2*IWIDTH-1:0]   in_data,
    output logic                  acc_val,
    input  logic                  acc_rdy,
    output logic [2*AWIDTH-1:0]   acc_data,
    output logic [CWIDTH-1:0]     acc_cnt
);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t                    state;
    logic signed [AWIDTH-1:0]  acc_x;
    logic signed [AWIDTH-1:0]  acc_y;
    logic        [CWIDTH-1:0]  cnt;

    logic signed [IWIDTH-1:0]  xr;
    logic signed [IWIDTH-1:0]  yr;
    logic signed [AWIDTH-1:0]  xr_ext;
    logic signed [AWIDTH-1:0]  yr_ext;
    logic                      in_ld;
    logic                      frame_end;

    // Split the input parts and sign-extend them to accumulator width; the
    // accumulator is wide enough for NACC worst-case terms, so no wrap logic.
    always_comb begin
        xr        = in_data[2*IWIDTH-1:IWIDTH];
        yr        = in_data[IWIDTH-1:0];
        xr_ext    = AWIDTH'(xr);
        yr_ext    = AWIDTH'(yr);
        in_ld     = in_val & in_rdy;
        frame_end = in_last | (cnt == CWIDTH'(NACC-1));
    end

    // Frame FSM: accumulate in ACC, present the result in HOLD until taken.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state   <= ST_ACC;
            in_rdy  <= 1'b1;
            acc_val <= 1'b0;
            acc_x   <= '0;
            acc_y   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_ld) begin
                        acc_x <= acc_x + xr_ext;
                        acc_y <= acc_y + yr_ext;
                        cnt   <= cnt + CWIDTH'(1);
                        // in_last on the NACC-th term closes the frame once
                        if (frame_end) begin
                            state   <= ST_HOLD;
                            in_rdy  <= 1'b0;
                            acc_val <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (acc_rdy) begin
                        state   <= ST_ACC;
                        in_rdy  <= 1'b1;
                        acc_val <= 1'b0;
                        acc_x   <= '0;
                        acc_y   <= '0;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state   <= ST_ACC;
                    in_rdy  <= 1'b1;
                    acc_val <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from the registers; in ACC they show the partial sum.
    always_comb begin
        acc_data = {acc_x, acc_y};
        acc_cnt  = cnt;
    end

endmodule
